c17_lane_pipe: RTL

// - Parametrised, pipelined successor to the single-shot c17 NAND benchmark: LANES independent c17 evaluators.
// - Valid/ready streaming interface; result pipelined over STAGES registers.
// - On-chip MISR signature and beat counter, so the netlist can be exercised and checked at speed.
// - Sits between the benchmark stimulus source and the result checker in the netlist test harness.

---
 rtl/c17_pkg.sv | 24 ++
 rtl/c17_pipe_stage.sv | 52 +++++
 rtl/c17_lane_pipe.sv | 114 +++++++++++
 3 files changed

// File: rtl/c17_pkg.sv
// c17_pkg: shared widths, lane types and the c17 NAND evaluator.
//   C17_IN_W   bits per lane input  {nx6, nx2, test[2], test[1], test[0]}
//   C17_OUT_W  bits per lane output {nx23, nx22}
//   c17_eval   six-NAND2 c17 netlist, gate for gate
package c17_pkg;

  localparam int unsigned C17_IN_W  = 5;
  localparam int unsigned C17_OUT_W = 2;

  typedef logic [C17_IN_W-1:0]  lane_in_t;
  typedef logic [C17_OUT_W-1:0] lane_out_t;

  function automatic lane_out_t c17_eval(input lane_in_t lane_in);
    logic t0, t1, t2, nx2, nx6;
    logic n0, n1, n2, n3;
    {nx6, nx2, t2, t1, t0} = lane_in;
    n0 = ~(t2 & t0);
    n1 = ~(t0 & nx6);
    n2 = ~(t1 & n1);
    n3 = ~(nx2 & n1);
    return {~(n3 & n2), ~(n0 & n3)};
  endfunction

endpackage

// File: rtl/c17_pipe_stage.sv
// c17_pipe_stage: one valid/data register slice of the result pipeline.
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   up_valid   upstream beat valid
//   up_data    upstream beat payload
//   dn_ready   downstream slice (or consumer) can take a beat
//   rdy        this slice can take a beat: empty, or draining this cycle
//   valid      slice holds a beat
//   data       slice payload
module c17_pipe_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  input  logic [W-1:0] up_data,
  input  logic         dn_ready,
  output logic         rdy,
  output logic         valid,
  output logic [W-1:0] data
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d,  data_q;

  // Payload only moves with a valid beat, so idle input garbage never
  // reaches the register and a drained slice keeps its last value.
  always_comb begin
    rdy     = ~valid_q | dn_ready;
    valid_d = valid_q;
    data_d  = data_q;
    if (rdy) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/c17_lane_pipe.sv
// c17_lane_pipe: LANES parallel c17 evaluators feeding a STAGES-deep
// valid/ready pipeline, with a MISR signature and saturating beat counter
// over every delivered result beat.
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   in_valid    in_data beat offered
//   in_ready    beat accepted this cycle when in_valid is high
//   in_data     lane k = in_data[5k+4:5k] = {nx6,nx2,t2,t1,t0}
//   out_valid   out_data holds a result beat
//   out_ready   consumer takes the beat this cycle
//   out_data    lane k = out_data[2k+1:2k] = {nx23,nx22}
//   sig_clear   synchronous clear of sig/beat_cnt (a same-cycle beat seeds them)
//   sig         MISR signature of delivered beats
//   beat_cnt    delivered beats, saturating at 16'hFFFF
module c17_lane_pipe
  import c17_pkg::*;
#(
  parameter int unsigned        LANES  = 4,
  parameter int unsigned        STAGES = 2,
  parameter logic [2*LANES-1:0] POLY   = 8'hB8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5*LANES-1:0]    in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*LANES-1:0]    out_data,
  input  logic                  sig_clear,
  output logic [2*LANES-1:0]    sig,
  output logic [15:0]           beat_cnt
);

  localparam int unsigned SIGW = 2 * LANES;

  logic [SIGW-1:0] eval_data;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign eval_data[C17_OUT_W*k +: C17_OUT_W] = c17_eval(in_data[C17_IN_W*k +: C17_IN_W]);
  end

  // Each slice owns its handshake nets so the combinational ready chain
  // runs through distinct signals rather than bits of one shared vector.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic            up_valid;
    logic [SIGW-1:0] up_data;
    logic            dn_ready;
    logic            rdy;
    logic            valid;
    logic [SIGW-1:0] data;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = eval_data;
    end else begin : g_body
      assign up_valid = g_stage[i-1].valid;
      assign up_data  = g_stage[i-1].data;
    end

    if (i == STAGES - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_mid
      assign dn_ready = g_stage[i+1].rdy;
    end

    c17_pipe_stage #(.W(SIGW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_valid),
      .up_data  (up_data),
      .dn_ready (dn_ready),
      .rdy      (rdy),
      .valid    (valid),
      .data     (data)
    );
  end

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = g_stage[STAGES-1].valid;
  assign out_data  = g_stage[STAGES-1].data;

  logic            deliver;
  logic [SIGW-1:0] sig_d, sig_q;
  logic [15:0]     beat_cnt_d, beat_cnt_q;

  always_comb begin
    deliver    = out_valid & out_ready;
    sig_d      = sig_q;
    beat_cnt_d = beat_cnt_q;
    if (sig_clear) begin
      sig_d      = deliver ? out_data : '0;
      beat_cnt_d = deliver ? 16'd1 : '0;
    end else if (deliver) begin
      sig_d = {sig_q[SIGW-2:0], 1'b0} ^ (sig_q[SIGW-1] ? POLY : '0) ^ out_data;
      if (beat_cnt_q != '1) begin
        beat_cnt_d = beat_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      sig_q      <= sig_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign sig      = sig_q;
  assign beat_cnt = beat_cnt_q;

endmodule
